// File: rtl/instr_decode_if.sv
// Fetch/decode/execute handshake bundle for instr_decode_stage.
// illegal_seen exists only when DECODE_ILLEGAL_TRAP_EN is defined.
interface instr_decode_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            LUP;
  logic            UB;
  logic            CB;
  logic            MEM;
  logic            ALU_IMM;
  logic            ALU_REG;
  logic            IOP;
  logic            FC;
  logic [2:0]      finite_control_sig;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [31:0]     port2_imm;
  logic [XLEN-1:0] pc_out;
  logic            illegal;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic            illegal_seen;
`endif

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, LUP, UB, CB, MEM, ALU_IMM, ALU_REG, IOP, FC,
           finite_control_sig, rs1, rs2, rd, port2_imm, pc_out, illegal
`ifdef DECODE_ILLEGAL_TRAP_EN
           , illegal_seen
`endif
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, LUP, UB, CB, MEM, ALU_IMM, ALU_REG, IOP, FC,
           finite_control_sig, rs1, rs2, rd, port2_imm, pc_out, illegal
`ifdef DECODE_ILLEGAL_TRAP_EN
           , illegal_seen
`endif
  );
endinterface

// File: rtl/instr_decode_stage.sv
// RV32I decode stage with a 2-entry skid queue between fetch and execute.
// Optional macro DECODE_ILLEGAL_TRAP_EN: flag illegal entries and keep a sticky illegal_seen.
module instr_decode_stage #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  instr_decode_if.slave bus
);

  typedef struct packed {
    logic            lup;
    logic            ub;
    logic            cb;
    logic            mem;
    logic            alu_imm;
    logic            alu_reg;
    logic            iop;
    logic            fc;
    logic [2:0]      fcs;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [XLEN-1:0] pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic            illegal;
`endif
  } dec_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  function automatic dec_t decode(input logic [31:0] w, input logic [XLEN-1:0] pc);
    dec_t        d;
    dec_t        bub;
    logic        legal;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    f3    = w[14:12];
    f7    = w[31:25];
    imm_i = {{20{w[31]}}, w[31:20]};
    imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
    imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    imm_u = {w[31:12], 12'b0};
    bub     = '0;
    bub.rs1 = w[19:15];
    bub.rs2 = w[24:20];
    bub.rd  = w[11:7];
    bub.pc  = pc;
    d       = bub;
    d.fc    = 1'b1;
    d.fcs   = f3;
    legal   = 1'b0;
    if (w[1:0] == 2'b11) begin
      case (w[6:2])
        5'b01101: begin d.lup = 1'b1; d.iop = 1'b1; d.fc = 1'b0; d.fcs = '0; d.imm = imm_u; legal = 1'b1; end
        5'b00101: begin d.lup = 1'b1; d.fc = 1'b0; d.fcs = '0; d.imm = imm_u; legal = 1'b1; end
        5'b11011: begin d.ub = 1'b1; d.fcs = 3'b010; d.imm = imm_j; legal = 1'b1; end
        5'b11001: begin d.ub = 1'b1; d.fcs = 3'b011; d.imm = imm_i; legal = (f3 == 3'b000); end
        5'b11000: begin d.cb = 1'b1; d.imm = imm_b; legal = (f3 != 3'b010) && (f3 != 3'b011); end
        5'b00000: begin
          d.mem = 1'b1; d.imm = imm_i;
          legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        end
        5'b01000: begin d.mem = 1'b1; d.iop = 1'b1; d.imm = imm_s; legal = (f3 <= 3'b010); end
        5'b00100: begin
          d.alu_imm = 1'b1; d.imm = imm_i;
          d.iop     = (f3 == 3'b101) ? w[30] : 1'b0;
          if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
          else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          else                   legal = 1'b1;
        end
        5'b01100: begin
          d.alu_reg = 1'b1;
          d.iop     = ((f3 == 3'b000) || (f3 == 3'b101)) ? w[30] : 1'b0;
          legal     = (f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        end
        default: legal = 1'b0;
      endcase
    end
    if (!legal) begin
      d = bub;
`ifdef DECODE_ILLEGAL_TRAP_EN
      d.illegal = 1'b1;
`endif
    end
    return d;
  endfunction

  state_e state_q, state_d;
  dec_t   ent_q [QDEPTH];
  dec_t   ent_d [QDEPTH];
  dec_t   dec_in;
  dec_t   head;
  logic   push, pop;

  assign dec_in        = decode(bus.in_instr, bus.in_pc);
  assign bus.in_ready  = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Flush wins over push and pop; entry 0 is always the head.
  always_comb begin
    state_d = state_q;
    ent_d   = ent_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin state_d = ONE; ent_d[0] = dec_in; end
        ONE: begin
          if (push && pop)  ent_d[0] = dec_in;
          else if (push)    begin state_d = TWO; ent_d[1] = dec_in; end
          else if (pop)     state_d = EMPTY;
        end
        TWO: if (pop) begin state_d = ONE; ent_d[0] = ent_q[1]; end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  // Payload is only meaningful while valid; force zeros otherwise.
  assign head = bus.out_valid ? ent_q[0] : '0;

  assign bus.LUP                = head.lup;
  assign bus.UB                 = head.ub;
  assign bus.CB                 = head.cb;
  assign bus.MEM                = head.mem;
  assign bus.ALU_IMM            = head.alu_imm;
  assign bus.ALU_REG            = head.alu_reg;
  assign bus.IOP                = head.iop;
  assign bus.FC                 = head.fc;
  assign bus.finite_control_sig = head.fcs;
  assign bus.rs1                = head.rs1;
  assign bus.rs2                = head.rs2;
  assign bus.rd                 = head.rd;
  assign bus.port2_imm          = head.imm;
  assign bus.pc_out             = head.pc;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic seen_q, seen_d;
  assign seen_d = seen_q | (pop & head.illegal);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seen_q <= 1'b0;
    else     seen_q <= seen_d;
  end
  assign bus.illegal      = head.illegal;
  assign bus.illegal_seen = seen_q;
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: directed test-plan cases, then random traffic.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_decode_if #(.XLEN(32)) bus();

  instr_decode_stage #(.XLEN(32), .QDEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0]  sel;
    logic        iop;
    logic        fc;
    logic [2:0]  fcs;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  logic seen_m = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction-set rules, using integer arithmetic for immediates.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int   op, f3, f7, sw, sgn;
    bit   ok;
    op  = int'(w[6:2]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    sw  = $signed(w);
    sgn = sw >>> 31;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.pc = pc;
    e.sel = 6'b0; e.iop = 1'b0; e.fc = 1'b1; e.fcs = w[14:12]; e.imm = 32'd0; e.ill = 1'b0;
    ok = 1'b0;
    case (op)
      'h0D: begin ok = 1; e.sel = 6'b100000; e.iop = 1; e.fc = 0; e.imm = w & 32'hFFFFF000; end
      'h05: begin ok = 1; e.sel = 6'b100000; e.fc = 0; e.imm = w & 32'hFFFFF000; end
      'h1B: begin
        ok = 1; e.sel = 6'b010000; e.fcs = 3'd2;
        e.imm = sgn * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      end
      'h19: begin ok = (f3 == 0); e.sel = 6'b010000; e.fcs = 3'd3; e.imm = sw >>> 20; end
      'h18: begin
        ok = !(f3 == 2 || f3 == 3); e.sel = 6'b001000;
        e.imm = sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      end
      'h00: begin ok = (f3 inside {0, 1, 2, 4, 5}); e.sel = 6'b000100; e.imm = sw >>> 20; end
      'h08: begin
        ok = (f3 <= 2); e.sel = 6'b000100; e.iop = 1;
        e.imm = (sw >>> 25) * 32 + int'(w[11:7]);
      end
      'h04: begin
        e.sel = 6'b000010; e.imm = sw >>> 20;
        e.iop = (f3 == 5) ? w[30] : 1'b0;
        ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
      end
      'h0C: begin
        e.sel = 6'b000001;
        e.iop = (f3 == 0 || f3 == 5) ? w[30] : 1'b0;
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      end
      default: ok = 0;
    endcase
    if (w[1:0] != 2'b11) ok = 0;
    if (!ok) begin
      e.sel = 6'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      e.ill = 1'b1;
`endif
    end
    return e;
  endfunction

  // Stimulus recorder: what fetch hands over this cycle is expected next.
  always @(negedge clk) begin : recorder
    logic f, acc;
    exp_t e;
    if (!rst) begin
      f   = bus.flush;
      acc = bus.in_valid && bus.in_ready;
      e   = model(bus.in_instr, bus.in_pc);
      #1;
      if (f)        sb.delete();
      else if (acc) sb.push_back(e);
    end
  end

  // Monitor: occupancy, then pop-and-compare on every output transfer.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, sb.size() < 2});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() > 0});
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("illegal_seen", {31'd0, bus.illegal_seen}, {31'd0, seen_m});
`endif
      if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sel", {26'd0, bus.LUP, bus.UB, bus.CB, bus.MEM, bus.ALU_IMM, bus.ALU_REG}, {26'd0, e.sel});
        chk("rs1", {27'd0, bus.rs1}, {27'd0, e.rs1});
        chk("rs2", {27'd0, bus.rs2}, {27'd0, e.rs2});
        chk("rd", {27'd0, bus.rd}, {27'd0, e.rd});
        chk("pc_out", bus.pc_out, e.pc);
        chk("illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
        if (e.sel != 6'b0) begin
          chk("iop", {31'd0, bus.IOP}, {31'd0, e.iop});
          chk("fc", {31'd0, bus.FC}, {31'd0, e.fc});
          chk("imm", bus.port2_imm, e.imm);
          if (e.fc) chk("fcs", {29'd0, bus.finite_control_sig}, {29'd0, e.fcs});
        end
        if (e.ill) seen_m = 1'b1;
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] w, input logic [31:0] pc,
                     input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  initial begin
    logic [31:0] w;
    logic        fl;
    rst = 1'b1;
    bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.out_ready = 0; bus.flush = 0;
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_sel", {26'd0, bus.LUP, bus.UB, bus.CB, bus.MEM, bus.ALU_IMM, bus.ALU_REG}, 32'd0);
    chk("rst_imm", bus.port2_imm, 32'd0);
    chk("rst_pc", bus.pc_out, 32'd0);
    chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // ADDI x1,x2,-1
    cyc(1, 32'hFFF10093, 32'h0, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    chk("addi_sel", {26'd0, bus.LUP, bus.UB, bus.CB, bus.MEM, bus.ALU_IMM, bus.ALU_REG}, 32'h2);
    chk("addi_imm", bus.port2_imm, 32'hFFFFFFFF);
    chk("addi_rs1", {27'd0, bus.rs1}, 32'd2);
    // SUB x3,x1,x2
    cyc(1, 32'h402081B3, 32'h4, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    chk("sub_iop", {31'd0, bus.IOP}, 32'd1);
    chk("sub_rd", {27'd0, bus.rd}, 32'd3);
    // JAL x1,+8
    cyc(1, 32'h008000EF, 32'h100, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    chk("jal_imm", bus.port2_imm, 32'd8);
    chk("jal_pc", bus.pc_out, 32'h100);
    chk("jal_fcs", {29'd0, bus.finite_control_sig}, 32'd2);
    // LUI x5,0x12345
    cyc(1, 32'h123452B7, 32'h8, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    chk("lui_imm", bus.port2_imm, 32'h12345000);
    chk("lui_fc", {31'd0, bus.FC}, 32'd0);

    // Backpressure: three back-to-back pushes with execute stalled
    cyc(1, 32'h00100093, 32'h200, 0, 0);
    cyc(1, 32'h00200113, 32'h204, 0, 0);
    cyc(1, 32'h00300193, 32'h208, 0, 0);
    @(negedge clk);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_head_pc", bus.pc_out, 32'h200);
    cyc(1, 32'h00300193, 32'h208, 0, 0);
    @(negedge clk);
    chk("bp_hold_pc", bus.pc_out, 32'h200);
    cyc(1, 32'h00300193, 32'h208, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    repeat (3) cyc(0, 32'h0, 32'h0, 1, 0);

    // Flush in TWO with a valid incoming word
    cyc(1, 32'h00400213, 32'h300, 0, 0);
    cyc(1, 32'h00500293, 32'h304, 0, 0);
    cyc(1, 32'h00600313, 32'h308, 0, 1);
    cyc(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Illegal opcode
    cyc(1, 32'h0000007F, 32'h400, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    chk("ill_sel", {26'd0, bus.LUP, bus.UB, bus.CB, bus.MEM, bus.ALU_IMM, bus.ALU_REG}, 32'd0);
    chk("ill_pc", bus.pc_out, 32'h400);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill_flag", {31'd0, bus.illegal}, 32'd1);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        w[6:0] = ops[$urandom_range(0, 8)];
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      fl = ($urandom_range(0, 39) == 0);
      cyc($urandom_range(0, 3) != 0, w, $urandom, fl ? 1'b0 : ($urandom_range(0, 2) != 0), fl);
    end
    repeat (4) cyc(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    #2;
    chk("drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
